// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives instruction_memory, captures into IF/ID.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stalls counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h00000000,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid,
   output logic        fault
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stalls
`endif
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        valid;
   } ifid_t;

   state_t      state, state_nxt;
   logic [31:0] pc;
   ifid_t       ifid;

   logic        do_redirect;
   logic        do_capture;
   logic        do_stall;
   logic        misaligned;

   assign misaligned = (redirect_target[1:0] != 2'b00);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= BOOT;
      else     state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         BOOT:    state_nxt = RUN;
         RUN:     if (redirect_valid && misaligned) state_nxt = FAULT;
         FAULT:   state_nxt = FAULT;
         default: state_nxt = BOOT;
      endcase
   end

   // control decode; redirect outranks stall, and only RUN acts on either
   always_comb begin
      do_redirect = 1'b0;
      do_capture  = 1'b0;
      do_stall    = 1'b0;
      fault       = 1'b0;
      case (state)
         RUN: begin
            do_redirect = redirect_valid;
            do_stall    = !redirect_valid && stall;
            do_capture  = !redirect_valid && !stall;
         end
         FAULT:   fault = 1'b1;
         default: ;
      endcase
   end

   // PC and IF/ID register; a misaligned target is still loaded so the trap PC is visible
   always_ff @(posedge clk) begin
      if (rst) begin
         pc         <= RESET_PC;
         ifid.pc    <= 32'h0;
         ifid.instr <= NOP_INSTR;
         ifid.valid <= 1'b0;
      end else if (do_redirect) begin
         pc         <= redirect_target;
         ifid.pc    <= 32'h0;
         ifid.instr <= NOP_INSTR;
         ifid.valid <= 1'b0;
      end else if (do_capture) begin
         pc         <= pc + 32'd4;
         ifid.pc    <= pc;
         ifid.instr <= imem_data;
         ifid.valid <= 1'b1;
      end
   end

   assign imem_addr = pc;
   assign if_pc     = ifid.pc;
   assign if_instr  = ifid.instr;
   assign if_valid  = ifid.valid;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched <= 32'h0;
         perf_stalls  <= 32'h0;
      end else begin
         if (do_capture) perf_fetched <= perf_fetched + 32'd1;
         if (do_stall)   perf_stalls  <= perf_stalls + 32'd1;
      end
   end
`else
   logic unused_stall;
   assign unused_stall = do_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst, stall, redirect_valid;
   logic [31:0] redirect_target, imem_addr, imem_data, if_pc, if_instr;
   logic        if_valid, fault;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched, perf_stalls;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .if_pc(if_pc), .if_instr(if_instr), .if_valid(if_valid), .fault(fault)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
   );

   // three real words at 0/4/8, an address-tagged filler elsewhere
   always_comb begin
      case (imem_addr)
         32'h0:   imem_data = 32'h00000013;
         32'h4:   imem_data = 32'h00100093;
         32'h8:   imem_data = 32'h00200113;
         default: imem_data = 32'h10000000 ^ imem_addr;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic vld, input logic [31:0] addr);
      chk({tag, ".if_pc"}, if_pc, pc);
      chk({tag, ".if_instr"}, if_instr, instr);
      chk({tag, ".if_valid"}, {31'b0, if_valid}, {31'b0, vld});
      chk({tag, ".imem_addr"}, imem_addr, addr);
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      tick();
      chk_ifid("reset", 32'h0, 32'h13, 1'b0, 32'h0);
      chk("reset.fault", {31'b0, fault}, 32'h0);
      rst = 1'b0;
      tick();
      chk_ifid("boot", 32'h0, 32'h13, 1'b0, 32'h0);
      tick();
      chk_ifid("seq0", 32'h0, 32'h00000013, 1'b1, 32'h4);
      tick();
      chk_ifid("seq1", 32'h4, 32'h00100093, 1'b1, 32'h8);

      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_ifid("stall", 32'h4, 32'h00100093, 1'b1, 32'h8);
      end
      stall = 1'b0;
      tick();
      chk_ifid("seq2", 32'h8, 32'h00200113, 1'b1, 32'hC);
      tick();
      chk_ifid("seq3", 32'hC, 32'h1000000C, 1'b1, 32'h10);

      redirect_valid = 1'b1; redirect_target = 32'h10; stall = 1'b1;
      tick();
      chk_ifid("redir_stall", 32'h0, 32'h13, 1'b0, 32'h10);
      redirect_valid = 1'b0; stall = 1'b0;
      tick();
      chk_ifid("redir_post", 32'h10, 32'h10000010, 1'b1, 32'h14);
`ifdef FETCH_PERF_CNT_EN
      chk("perf.fetched", perf_fetched, 32'd5);
      chk("perf.stalls", perf_stalls, 32'd3);
`endif

      // reset mid-run beats a pending redirect, and BOOT ignores it afterwards
      rst = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
      tick();
      chk_ifid("midrst", 32'h0, 32'h13, 1'b0, 32'h0);
      chk("midrst.fault", {31'b0, fault}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("midrst.perf_fetched", perf_fetched, 32'd0);
      chk("midrst.perf_stalls", perf_stalls, 32'd0);
`endif
      rst = 1'b0;
      tick();
      chk_ifid("boot_redir", 32'h0, 32'h13, 1'b0, 32'h0);
      redirect_valid = 1'b0;
      tick();
      chk_ifid("run_again", 32'h0, 32'h13, 1'b1, 32'h4);

      redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
      tick();
      chk_ifid("wrap_redir", 32'h0, 32'h13, 1'b0, 32'hFFFFFFFC);
      redirect_valid = 1'b0;
      tick();
      chk_ifid("wrap_top", 32'hFFFFFFFC, 32'hEFFFFFFC, 1'b1, 32'h0);
      tick();
      chk_ifid("wrap_zero", 32'h0, 32'h13, 1'b1, 32'h4);
      chk("wrap.fault", {31'b0, fault}, 32'h0);

      redirect_valid = 1'b1; redirect_target = 32'h12; stall = 1'b1;
      tick();
      chk_ifid("misal", 32'h0, 32'h13, 1'b0, 32'h12);
      chk("misal.fault", {31'b0, fault}, 32'h1);
      for (int i = 0; i < 5; i++) begin
         stall = i[0]; redirect_valid = ~i[0]; redirect_target = 32'h20 + 32'(i * 4);
         tick();
         chk_ifid("fault_hold", 32'h0, 32'h13, 1'b0, 32'h12);
         chk("fault_hold.fault", {31'b0, fault}, 32'h1);
      end
      rst = 1'b1; redirect_valid = 1'b0; stall = 1'b0;
      tick();
      chk_ifid("fault_rst", 32'h0, 32'h13, 1'b0, 32'h0);
      chk("fault_rst.fault", {31'b0, fault}, 32'h0);

      // stall is ignored in BOOT but honoured in RUN
      rst = 1'b0; stall = 1'b1;
      tick();
      chk_ifid("boot_stall", 32'h0, 32'h13, 1'b0, 32'h0);
      tick();
      chk_ifid("run_stall", 32'h0, 32'h13, 1'b0, 32'h0);
      stall = 1'b0;
      tick();
      chk_ifid("run_release", 32'h0, 32'h13, 1'b1, 32'h4);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
